// File: rtl/s298_resp_capture_pkg.sv
// rtl/s298_resp_capture_pkg.sv - shared types, defaults and MISR step for the s298 response capture
package s298_cap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          VEC_W          = 6;
    localparam int          TS_W_DEF       = 10;
    localparam logic [15:0] MISR_POLY_DEF  = 16'h100B;
    localparam logic [15:0] MISR_SEED_DEF  = 16'hFFFF;

    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
        logic [VEC_W-1:0]    vec;
    } evt_t;

    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [15:0] poly,
                                              input logic [VEC_W-1:0] v);
        return {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ {10'b0, v};
    endfunction

endpackage

// File: rtl/s298_resp_capture_if.sv
// rtl/s298_resp_capture_if.sv - event stream handshake between the capture block and its consumer
interface s298_resp_capture_if #(
    parameter int TS_W = 10
) ();
    logic              EVT_VALID;
    logic              EVT_READY;
    logic [TS_W+5:0]   EVT_DATA;

    modport master (output EVT_VALID, output EVT_DATA, input EVT_READY);
    modport slave  (input EVT_VALID, input EVT_DATA, output EVT_READY);
endinterface

// File: rtl/s298_resp_capture_evt_fifo.sv
// rtl/s298_resp_capture_evt_fifo.sv - DEPTH-entry event FIFO, push accepted when full if a pop occurs
module s298_evt_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         accept,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         pop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = !empty && ready;
    assign accept = push && (!full || pop);
    assign valid  = !empty;
    // Drive zero when empty so the output matches its reset value
    assign data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/s298_resp_capture.sv
// rtl/s298_resp_capture.sv - samples s298 outputs into a windowed MISR and logs output changes as events
module s298_resp_capture
    import s298_cap_pkg::*;
#(
    parameter int          TS_W      = 10,
    parameter int          DEPTH     = 4,
    parameter int          WINDOW    = 256,
    parameter logic [15:0] MISR_POLY = MISR_POLY_DEF,
    parameter logic [15:0] MISR_SEED = MISR_SEED_DEF
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic                    START,
    input  logic                    G66,
    input  logic                    G67,
    input  logic                    G117,
    input  logic                    G118,
    input  logic                    G132,
    input  logic                    G133,
    s298_resp_capture_if.master     evt,
    output logic [15:0]             SIG,
    output logic                    SIG_DONE,
    output logic                    OVF,
    output logic                    BUSY
);
    localparam logic [TS_W-1:0] LAST    = TS_W'(WINDOW - 1);
    localparam logic [TS_W-1:0] CNT_ONE = TS_W'(1);

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [VEC_W-1:0] vec;
    } cap_evt_t;

    state_t           state_q;
    logic [TS_W-1:0]  count_q;
    logic             first_q;
    logic [VEC_W-1:0] prev_v;
    logic [VEC_W-1:0] v;
    logic             sample;
    logic             gen;
    logic             accept;
    cap_evt_t         new_evt;

    assign v       = {G133, G132, G118, G117, G67, G66};
    assign sample  = (state_q == RUN) && !START;
    assign gen     = sample && (first_q || (v != prev_v));
    assign new_evt = '{ts: count_q, vec: v};

    s298_evt_fifo #(
        .W     (TS_W + VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CK),
        .rst       (RST),
        .flush     (START),
        .push      (gen),
        .push_data (new_evt),
        .accept    (accept),
        .valid     (evt.EVT_VALID),
        .ready     (evt.EVT_READY),
        .data      (evt.EVT_DATA)
    );

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q  <= IDLE;
            count_q  <= '0;
            first_q  <= 1'b1;
            prev_v   <= '0;
            SIG      <= MISR_SEED;
            SIG_DONE <= 1'b0;
            OVF      <= 1'b0;
            BUSY     <= 1'b0;
        end else if (START) begin
            state_q  <= RUN;
            count_q  <= '0;
            first_q  <= 1'b1;
            SIG      <= MISR_SEED;
            SIG_DONE <= 1'b0;
            OVF      <= 1'b0;
            BUSY     <= 1'b1;
        end else if (state_q == RUN) begin
            SIG     <= misr_step(SIG, MISR_POLY, v);
            prev_v  <= v;
            first_q <= 1'b0;
            count_q <= count_q + CNT_ONE;
            // A change event with no room and no concurrent pop is lost
            if (gen && !accept) OVF <= 1'b1;
            if (count_q == LAST) begin
                state_q  <= DONE;
                SIG_DONE <= 1'b1;
                BUSY     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s298_resp_capture.sv
// tb/tb_s298_resp_capture.sv - self-checking bench for s298_resp_capture
module tb_s298_resp_capture;

    logic        CK = 1'b0;
    logic        RST;
    logic        start_a, start_b;
    logic [5:0]  va, vb;
    logic [15:0] sig_a, sig_b;
    logic        done_a, done_b, ovf_a, ovf_b, busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    logic [15:0] last_pop;

    // Reference state for the WINDOW=256 instance
    int          m_state;
    logic [9:0]  m_cnt;
    logic        m_first;
    logic [5:0]  m_prev;
    logic [15:0] m_sig;
    logic        m_done, m_ovf;
    logic [15:0] q[$];

    always #5 CK = ~CK;

    s298_resp_capture_if #(.TS_W(10)) ifa ();
    s298_resp_capture_if #(.TS_W(10)) ifb ();

    s298_resp_capture #(.WINDOW(256)) dut_a (
        .CK(CK), .RST(RST), .START(start_a),
        .G66(va[0]), .G67(va[1]), .G117(va[2]), .G118(va[3]), .G132(va[4]), .G133(va[5]),
        .evt(ifa.master), .SIG(sig_a), .SIG_DONE(done_a), .OVF(ovf_a), .BUSY(busy_a)
    );

    s298_resp_capture #(.WINDOW(1)) dut_b (
        .CK(CK), .RST(RST), .START(start_b),
        .G66(vb[0]), .G67(vb[1]), .G117(vb[2]), .G118(vb[3]), .G132(vb[4]), .G133(vb[5]),
        .evt(ifb.master), .SIG(sig_b), .SIG_DONE(done_b), .OVF(ovf_b), .BUSY(busy_b)
    );

    typedef struct {
        logic [5:0]  v;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [5:0] v);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {10'b0, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (!RST && !start_a && q.size() > 0 && ifa.EVT_READY) begin
            chk("pop_data", ifa.EVT_DATA, q[0]);
            pops++;
            last_pop = ifa.EVT_DATA;
        end
        @(posedge CK);
        if (RST) begin
            m_state = 0; m_cnt = '0; m_first = 1'b1; m_prev = '0;
            m_sig = 16'hFFFF; m_done = 1'b0; m_ovf = 1'b0; q.delete();
        end else if (start_a) begin
            q.delete();
            m_state = 1; m_cnt = '0; m_first = 1'b1;
            m_sig = 16'hFFFF; m_done = 1'b0; m_ovf = 1'b0;
        end else begin
            if (q.size() > 0 && ifa.EVT_READY) void'(q.pop_front());
            if (m_state == 1) begin
                if (m_first || va != m_prev) begin
                    if (q.size() < 4) q.push_back({m_cnt, va});
                    else m_ovf = 1'b1;
                end
                m_sig   = misr_model(m_sig, va);
                m_prev  = va;
                m_first = 1'b0;
                if (m_cnt == 10'd255) begin
                    m_state = 2;
                    m_done  = 1'b1;
                end
                m_cnt = m_cnt + 10'd1;
            end
        end
        #1;
        chk("evt_valid", ifa.EVT_VALID, q.size() > 0);
        chk("sig", sig_a, m_sig);
        chk("sig_done", done_a, m_done);
        chk("ovf", ovf_a, m_ovf);
        chk("busy", busy_a, m_state == 1);
    endtask

    initial begin
        RST = 1'b1; start_a = 1'b0; start_b = 1'b0; va = '0; vb = '0;
        ifa.EVT_READY = 1'b0; ifb.EVT_READY = 1'b0;

        tbl[0] = '{6'h15, 1'b0, 1'b1, 16'h0015, 1'b0};
        tbl[1] = '{6'h2A, 1'b0, 1'b1, 16'h0015, 1'b0};
        tbl[2] = '{6'h15, 1'b0, 1'b1, 16'h0015, 1'b0};
        tbl[3] = '{6'h2A, 1'b0, 1'b1, 16'h0015, 1'b0};
        tbl[4] = '{6'h15, 1'b0, 1'b1, 16'h0015, 1'b1};
        tbl[5] = '{6'h2A, 1'b0, 1'b1, 16'h0015, 1'b1};
        tbl[6] = '{6'h2A, 1'b1, 1'b1, 16'h006A, 1'b1};
        tbl[7] = '{6'h2A, 1'b1, 1'b1, 16'h0095, 1'b1};
        tbl[8] = '{6'h2A, 1'b1, 1'b1, 16'h00EA, 1'b1};
        tbl[9] = '{6'h2A, 1'b1, 1'b0, 16'h0000, 1'b1};

        // Reset and idle hold
        tick(); tick();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            va = 6'(k * 7 + 1);
            tick();
        end
        chk("idle_sig", sig_a, 16'hFFFF);
        chk("idle_valid", ifa.EVT_VALID, 1'b0);
        chk("idle_done", done_a, 1'b0);
        chk("idle_ovf", ovf_a, 1'b0);
        chk("idle_busy", busy_a, 1'b0);

        // Single-sample window on the second instance
        vb = 6'h01; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("w1_busy", busy_b, 1'b1);
        chk("w1_seed", sig_b, 16'hFFFF);
        tick();
        chk("w1_sig", sig_b, 16'hEFF4);
        chk("w1_done", done_b, 1'b1);
        chk("w1_busy_off", busy_b, 1'b0);
        chk("w1_valid", ifb.EVT_VALID, 1'b1);
        chk("w1_data", ifb.EVT_DATA, 16'h0001);
        ifb.EVT_READY = 1'b1; vb = 6'h3C;
        tick();
        chk("w1_one_evt", ifb.EVT_VALID, 1'b0);
        chk("w1_sig_hold", sig_b, 16'hEFF4);

        // Full window, constant vector
        va = 6'h00; ifa.EVT_READY = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0; pops = 0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k == 255) chk("w256_done_early", done_a, 1'b0);
            if (k == 256) chk("w256_done_edge", done_a, 1'b1);
        end
        chk("w256_pops", pops, 1);
        chk("w256_evt", last_pop, 16'h0000);

        // Alternating vector, overflow then drain
        ifa.EVT_READY = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0; pops = 0;
        for (int k = 0; k < 10; k++) begin
            va = tbl[k].v; ifa.EVT_READY = tbl[k].ready;
            tick();
            chk("tbl_valid", ifa.EVT_VALID, tbl[k].exp_valid);
            if (tbl[k].exp_valid) chk("tbl_head", ifa.EVT_DATA, tbl[k].exp_data);
            chk("tbl_ovf", ovf_a, tbl[k].exp_ovf);
        end
        chk("tbl_pops", pops, 4);

        // Full FIFO with simultaneous pop and push
        ifa.EVT_READY = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        va = 6'h15; tick();
        va = 6'h2A; tick();
        va = 6'h15; tick();
        va = 6'h2A; tick();
        va = 6'h15; ifa.EVT_READY = 1'b1; tick();
        ifa.EVT_READY = 1'b0; tick(); tick();
        chk("full_pp_ovf", ovf_a, 1'b0);
        chk("full_pp_head", ifa.EVT_DATA, 16'h006A);
        pops = 0; ifa.EVT_READY = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("full_pp_count", pops, 4);
        chk("full_pp_last", last_pop, 16'h0115);

        // Restart mid-run at sample 100
        ifa.EVT_READY = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 100; k++) begin
            va = 6'(k / 20);
            tick();
        end
        chk("pre_restart_ovf", ovf_a, 1'b1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_valid", ifa.EVT_VALID, 1'b0);
        chk("restart_sig", sig_a, 16'hFFFF);
        chk("restart_ovf", ovf_a, 1'b0);
        va = 6'h3F; ifa.EVT_READY = 1'b1;
        tick(); tick();
        chk("restart_ts0", last_pop, 16'h003F);

        // Reset mid-run with events pending
        ifa.EVT_READY = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0; va = 6'h07;
        tick(); tick(); tick();
        chk("pre_rst_valid", ifa.EVT_VALID, 1'b1);
        RST = 1'b1;
        tick();
        chk("rst_valid", ifa.EVT_VALID, 1'b0);
        chk("rst_data", ifa.EVT_DATA, 16'h0000);
        chk("rst_sig", sig_a, 16'hFFFF);
        chk("rst_done", done_a, 1'b0);
        chk("rst_ovf", ovf_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        RST = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
